// File: rtl/jtag_host.sv
// JTAG host: turns queued TAP_RESET / IR / DR / idle commands into TCK/TMS/TDI waveforms
// and returns the TDO bits captured during IR and DR shifts.
module jtag_host #(
  parameter int unsigned DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [4:0]  cmd_len,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO
);

  localparam int unsigned DW = 16;
  localparam int unsigned LW = 5;
  localparam int unsigned CW = 8;

  localparam logic [1:0] CMD_TAP_RESET = 2'd0;
  localparam logic [1:0] CMD_IR        = 2'd1;
  localparam logic [1:0] CMD_DR        = 2'd2;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SHIFT,
    TRAILER,
    RUNCYC
  } state_t;

  state_t          state_q, state_d, nxt;
  logic [1:0]      typ_q, typ_d;
  logic [LW-1:0]   len_q, len_d, acc_len;
  logic [DW-1:0]   data_q, data_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   div_q, div_d;
  logic [DW-1:0]   cap_q, cap_d;
  logic            tck_q, tck_d;
  logic            tms_q, tms_d;
  logic            tdi_q, tdi_d;
  logic            ready_q, ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;

  // Lengths of 0 behave as 1 and anything past the data width saturates.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (len == '0) return LW'(1);
    if (len > LW'(DW)) return LW'(DW);
    return len;
  endfunction

  function automatic logic is_scan(input logic [1:0] typ);
    return (typ == CMD_IR) || (typ == CMD_DR);
  endfunction

  // Index of the final TCK cycle spent in a given state.
  function automatic logic [LW-1:0] last_idx(input state_t st, input logic [1:0] typ,
                                             input logic [LW-1:0] len);
    logic [LW-1:0] r;
    r = '0;
    case (st)
      HEADER:  r = (typ == CMD_IR) ? LW'(3) : LW'(2);
      SHIFT:   r = len - LW'(1);
      TRAILER: r = LW'(1);
      RUNCYC:  r = (typ == CMD_TAP_RESET) ? LW'(5) : len - LW'(1);
      default: r = '0;
    endcase
    return r;
  endfunction

  // {TMS, TDI} to present for TCK cycle idx of state st.
  function automatic logic [1:0] pins(input state_t st, input logic [1:0] typ,
                                      input logic [LW-1:0] len, input logic [DW-1:0] data,
                                      input logic [LW-1:0] idx);
    logic tms, tdi;
    tms = 1'b0;
    tdi = 1'b0;
    case (st)
      HEADER:  tms = (typ == CMD_IR) ? (idx < LW'(2)) : (idx == '0);
      SHIFT: begin
        tms = (idx == len - LW'(1));
        tdi = data[idx[3:0]];
      end
      TRAILER: tms = (idx == '0);
      RUNCYC:  tms = (typ == CMD_TAP_RESET) && (idx < LW'(5));
      default: tms = 1'b0;
    endcase
    return {tms, tdi};
  endfunction

  always_comb begin
    state_d     = state_q;
    typ_d       = typ_q;
    len_d       = len_q;
    data_d      = data_q;
    idx_d       = idx_q;
    div_d       = div_q;
    cap_d       = cap_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    nxt         = state_q;
    acc_len     = '0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          acc_len = clamp_len(cmd_len);
          nxt     = is_scan(cmd_type) ? HEADER : RUNCYC;
          state_d = nxt;
          typ_d   = cmd_type;
          len_d   = acc_len;
          data_d  = cmd_data;
          idx_d   = '0;
          div_d   = '0;
          cap_d   = '0;
          tck_d   = 1'b0;
          ready_d = 1'b0;
          {tms_d, tdi_d} = pins(nxt, cmd_type, acc_len, cmd_data, '0);
        end
      end

      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + CW'(1);
        end else begin
          div_d = '0;
          tck_d = ~tck_q;
          if (!tck_q) begin
            // Rising edge: capture TDO for the current shift bit.
            if (state_q == SHIFT) cap_d[idx_q[3:0]] = TDO;
          end else begin
            // Falling edge: advance to the next TCK cycle and drive its pins.
            if (idx_q == last_idx(state_q, typ_q, len_q)) begin
              idx_d = '0;
              case (state_q)
                HEADER:  nxt = SHIFT;
                SHIFT:   nxt = TRAILER;
                default: nxt = IDLE;
              endcase
            end else begin
              idx_d = idx_q + LW'(1);
              nxt   = state_q;
            end
            state_d = nxt;
            if (nxt == IDLE) begin
              ready_d = 1'b1;
              tdi_d   = 1'b0;
              if (state_q == TRAILER) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = cap_q;
              end
            end else begin
              {tms_d, tdi_d} = pins(nxt, typ_q, len_q, data_q, idx_d);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      typ_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      div_q       <= '0;
      cap_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      typ_q       <= typ_d;
      len_q       <= len_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      cap_q       <= cap_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 The block SHALL have one parameter: DIV, default 2, meaning clk cycles per TCK half-period (legal 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the command input ports:
- cmd_valid, input, 1: command offered.
- cmd_ready, output, 1: host can accept a command.
- cmd_type, input, 2: 0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE_CYCLES.
- cmd_len, input, 5: bit count for scans, TCK count for idle.
- cmd_data, input, 16: shift data, LSB shifted first.
REQ-005 The block SHALL have the response output ports:
- rsp_valid, output, 1: one-clk pulse when a scan completes.
- rsp_data, output, 16: captured TDO bits.
REQ-006 The block SHALL have the JTAG ports:
- TCK, output, 1: JTAG clock.
- TMS, output, 1: JTAG mode select.
- TDI, output, 1: JTAG data to target.
- TDO, input, 1: JTAG data from target.

Function
REQ-007 TCK SHALL be low for DIV clk cycles, then high for DIV clk cycles, while a command runs; between commands it SHALL be held low.
REQ-008 TMS and TDI SHALL change only in the clk cycle TCK falls, or at command start while TCK is low; TDO SHALL be sampled in the clk cycle TCK rises.
REQ-009 A command SHALL be accepted on the clk edge where cmd_valid=1 and cmd_ready=1; the first TCK low phase SHALL begin on the next clk.
REQ-010 cmd_ready SHALL drop on acceptance and SHALL return high in the clk cycle after the final TCK falling edge of that command.
REQ-011 cmd_len SHALL be clamped: 0 acts as 1, and values above 16 act as 16.
REQ-012 TAP_RESET SHALL issue 6 TCK cycles with TMS=1,1,1,1,1,0 and TDI=0, ending in Run-Test/Idle.
REQ-013 IR_SCAN SHALL issue len+6 TCK cycles:
- header TMS=1,1,0,0;
- len shift cycles with TMS=0, except TMS=1 on the last bit;
- then TMS=1 (Update-IR), then TMS=0 (Run-Test/Idle).
REQ-014 DR_SCAN SHALL be identical to IR_SCAN except the header is TMS=1,0,0 (len+5 cycles).
REQ-015 During shift cycle i (0-based), TDI SHALL equal cmd_data[i]; outside shift cycles TDI SHALL be 0.
REQ-016 The TDO sampled on shift cycle i SHALL be stored in rsp_data[i]; bits len..15 SHALL be 0.
REQ-017 IDLE_CYCLES SHALL issue len TCK cycles with TMS=0 and TDI=0, and SHALL produce no rsp_valid.
REQ-018 For IR_SCAN and DR_SCAN, rsp_valid SHALL pulse for exactly one clk in the same cycle cmd_ready returns high.
REQ-019 rsp_data SHALL hold its value until the next scan completes.
REQ-020 The state machine SHALL have states IDLE, HEADER, SHIFT, TRAILER and RUNCYC (TAP_RESET and IDLE_CYCLES use RUNCYC with a TMS pattern).
REQ-021 cmd_* inputs SHALL be registered at acceptance; changes to them while busy SHALL have no effect.
REQ-022 If cmd_valid is held high with a new command, it SHALL be accepted in the same cycle cmd_ready returns high (back-to-back, no idle TCK).

Reset
REQ-023 While rst_n=0, the outputs SHALL be: TCK=0, TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0; the state SHALL be IDLE.
REQ-024 cmd_ready SHALL go high on the first clk edge after rst_n deasserts.
REQ-025 Reset asserted mid-command SHALL abort the command immediately, with no rsp_valid; software then issues TAP_RESET.

Verification
REQ-026 The bench SHALL cover: DIV=2, TAP_RESET -> 6 TCK periods of 4 clk each, TMS=111110, cmd_ready high after the 6th falling edge.
REQ-027 The bench SHALL cover: IR_SCAN len=4, data=0x5, TDO=0 -> TMS=1100 0001 10, TDI during shift=1,0,1,0, rsp_data=0x0000, one rsp_valid.
REQ-028 The bench SHALL cover: DR_SCAN len=10, data=0x2C2 with TDO looped to TDI through a 0-delay wire -> rsp_data=0x02C2 and 15 TCK periods.
REQ-029 The bench SHALL cover: DR_SCAN len=0, data=0xFFFF -> one shift bit, rsp_data=0x0001 under loopback; then len=20 -> 16 shift bits, rsp_data=0xFFFF.
REQ-030 The bench SHALL cover: cmd_valid held high for IDLE_CYCLES len=3 then DR_SCAN -> no gap between the 3rd TCK period and the DR header, and no rsp_valid for the idle command.
REQ-031 The bench SHALL cover: rst_n pulsed low during the 5th shift bit -> TCK=0, TMS=1 immediately, no rsp_valid, and cmd_ready=1 one clk after release.
